// File: rtl/gmem_responder.sv
// Global-memory responder: word array, fixed latency, round-robin over channels.
// Optional GMEM_PERF_CNT_EN builds saturating read/write completion counters.
module gmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 1,
  parameter int LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [CHANNELS-1:0]           read_ready,
  output logic [CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [CHANNELS-1:0]           write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [CHANNELS*DATA_BITS-1:0] write_data,
  output logic [CHANNELS-1:0]           write_ready,
  output logic [15:0]                   rd_count,
  output logic [15:0]                   wr_count
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                      r_state;
  logic [NW-1:0]               r_cnt;
  logic [CW-1:0]               r_ch;
  logic [CW-1:0]               r_last;
  logic                        r_is_wr;
  logic [ADDR_BITS-1:0]        r_addr;
  logic [DATA_BITS-1:0]        r_wdata;
  logic [DATA_BITS-1:0]        r_mem [DEPTH];
  logic [CHANNELS-1:0]         r_rready;
  logic [CHANNELS-1:0]         r_wready;
  logic [CHANNELS*DATA_BITS-1:0] r_rdata;
  logic [CHANNELS-1:0]         r_rd_block;
  logic [CHANNELS-1:0]         r_wr_block;

  logic [CHANNELS-1:0]         w_rd_elig;
  logic [CHANNELS-1:0]         w_wr_elig;
  logic [CHANNELS-1:0]         w_elig;
  logic                        w_hit;
  logic [CW-1:0]               w_ch;
  logic                        w_take_wr;
  logic [ADDR_BITS-1:0]        w_addr;
  logic [DATA_BITS-1:0]        w_wdata;

  assign w_rd_elig = read_valid & ~r_rd_block;
  assign w_wr_elig = write_valid & ~r_wr_block;
  assign w_elig    = w_rd_elig | w_wr_elig;

  // Walk from farthest to nearest so the channel just after r_last wins.
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last) + k) % CHANNELS;
      if (w_elig[idx]) begin
        w_hit = 1'b1;
        w_ch  = CW'(idx);
      end
    end
  end

  assign w_take_wr = w_wr_elig[w_ch];
  assign w_wdata   = write_data[int'(w_ch)*DATA_BITS +: DATA_BITS];
  assign w_addr    = w_take_wr ?
                     write_address[int'(w_ch)*ADDR_BITS +: ADDR_BITS] :
                     read_address[int'(w_ch)*ADDR_BITS +: ADDR_BITS];

  // Ready/commit happen on the edge leaving RESP, LATENCY edges after capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ch       <= '0;
      r_last     <= CW'(CHANNELS - 1);
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rready   <= '0;
      r_wready   <= '0;
      r_rdata    <= '0;
      r_rd_block <= '0;
      r_wr_block <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rready   <= '0;
      r_wready   <= '0;
      r_rd_block <= r_rd_block & read_valid;
      r_wr_block <= r_wr_block & write_valid;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_ch    <= w_ch;
            r_last  <= w_ch;
            r_is_wr <= w_take_wr;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= NW'((LATENCY > 1) ? LATENCY - 2 : 0);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else r_cnt <= r_cnt - 1'b1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_is_wr) begin
            r_mem[r_addr]    <= r_wdata;
            r_wready[r_ch]   <= 1'b1;
            r_wr_block[r_ch] <= 1'b1;
          end else begin
            r_rdata[int'(r_ch)*DATA_BITS +: DATA_BITS] <= r_mem[r_addr];
            r_rready[r_ch]   <= 1'b1;
            r_rd_block[r_ch] <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_ready  = r_rready;
  assign write_ready = r_wready;
  assign read_data   = r_rdata;

`ifdef GMEM_PERF_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic        w_rd_done;
  logic        w_wr_done;

  assign w_rd_done = (r_state == S_RESP) && !r_is_wr;
  assign w_wr_done = (r_state == S_RESP) && r_is_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_done && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_wr_done && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_gmem_responder.sv
// Directed bench for gmem_responder: 4 channels, LATENCY=2.
module tb_gmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  read_valid;
  logic [31:0] read_address;
  logic [3:0]  read_ready;
  logic [31:0] read_data;
  logic [3:0]  write_valid;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [3:0]  write_ready;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  gmem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edges from driving a request until the ready bit is seen; -1 on timeout.
  task automatic wait_rdy(input int ch, input bit wr, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (wr ? write_ready[ch] : read_ready[ch]) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  task automatic do_wr(input int ch, input logic [7:0] a, input logic [7:0] d,
                       input string tag);
    int n;
    write_address[ch*8 +: 8] = a;
    write_data[ch*8 +: 8]    = d;
    write_valid[ch]          = 1'b1;
    wait_rdy(ch, 1'b1, n);
    chk(tag, n, 3);
    write_valid[ch] = 1'b0;
    cyc();
  endtask

  task automatic do_rd(input int ch, input logic [7:0] a, input logic [7:0] d,
                       input string tag);
    int n;
    read_address[ch*8 +: 8] = a;
    read_valid[ch]          = 1'b1;
    wait_rdy(ch, 1'b0, n);
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_data"}, read_data[ch*8 +: 8], d);
    read_valid[ch] = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    int t [4];
    logic [7:0] d [4];
    int ov;
    int tw, tr;
    logic [7:0] dr;

    reset = 1'b1;
    read_valid = '0; write_valid = '0;
    read_address = '0; write_address = '0; write_data = '0;
    repeat (2) cyc();
    chk("rst_rready", read_ready, 0);
    chk("rst_wready", write_ready, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_rdcnt", rd_count, 0);
    reset = 1'b0;
    cyc();

    // Read of fresh memory, then one-cycle pulse check.
    read_address[7:0] = 8'h10;
    read_valid[0] = 1'b1;
    wait_rdy(0, 1'b0, n);
    chk("t1_lat", n, 3);
    chk("t1_data", read_data[7:0], 8'h00);
    read_valid[0] = 1'b0;
    cyc();
    chk("t1_pulse", read_ready, 0);

    do_wr(0, 8'h3C, 8'hA5, "t2_wlat");
    do_rd(0, 8'h3C, 8'hA5, "t2_rd");

    // Preload through ch3 so the pointer wraps to ch0 next.
    for (int i = 0; i < 4; i++) do_wr(3, 8'(i), 8'(8'h11 * (i + 1)), "t3_pre");
    for (int i = 0; i < 4; i++) begin
      read_address[i*8 +: 8] = 8'(i);
      t[i] = -1;
      d[i] = 8'h00;
    end
    read_valid = 4'hF;
    ov = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if ($countones({read_ready, write_ready}) > 1) ov++;
      for (int i = 0; i < 4; i++) begin
        if (read_ready[i]) begin
          t[i] = c;
          d[i] = read_data[i*8 +: 8];
          read_valid[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_time%0d", i), t[i], 3 + 3 * i);
      chk($sformatf("t3_data%0d", i), d[i], 8'h11 * (i + 1));
    end
    chk("t3_overlap", ov, 0);

    // Held valid must not produce a duplicate response.
    read_address[7:0] = 8'h3C;
    read_valid[0] = 1'b1;
    wait_rdy(0, 1'b0, n);
    chk("t4_lat", n, 3);
    ov = 0;
    repeat (4) begin
      cyc();
      if (read_ready[0]) ov++;
    end
    chk("t4_nodup", ov, 0);
    read_valid[0] = 1'b0;
    cyc();
    read_valid[0] = 1'b1;
    wait_rdy(0, 1'b0, n);
    chk("t4_relat", n, 3);
    chk("t4_redata", read_data[7:0], 8'hA5);
    read_valid[0] = 1'b0;
    cyc();

    // Same-cycle write and read on one channel: write goes first.
    write_address[7:0] = 8'h07;
    write_data[7:0]    = 8'h5A;
    read_address[7:0]  = 8'h07;
    write_valid[0] = 1'b1;
    read_valid[0]  = 1'b1;
    tw = -1; tr = -1; dr = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (write_ready[0]) begin
        tw = c;
        write_valid[0] = 1'b0;
      end
      if (read_ready[0]) begin
        tr = c;
        dr = read_data[7:0];
        read_valid[0] = 1'b0;
      end
    end
    chk("t5_wtime", tw, 3);
    chk("t5_rtime", tr, 6);
    chk("t5_rdata", dr, 8'h5A);
`ifdef GMEM_PERF_CNT_EN
    chk("t5_rdcnt", rd_count, 9);
    chk("t5_wrcnt", wr_count, 6);
`else
    chk("t5_rdcnt", rd_count, 0);
    chk("t5_wrcnt", wr_count, 0);
`endif

    // Reset while the write sits in WAIT.
    write_address[7:0] = 8'h20;
    write_data[7:0]    = 8'hFF;
    write_valid[0] = 1'b1;
    cyc();
    reset = 1'b1;
    write_valid[0] = 1'b0;
    #1;
    chk("t6_rst_wready", write_ready, 0);
    chk("t6_rst_wrcnt", wr_count, 0);
    cyc();
    reset = 1'b0;
    ov = 0;
    repeat (4) begin
      cyc();
      if (write_ready != 0) ov++;
    end
    chk("t6_nowr", ov, 0);
    do_rd(0, 8'h20, 8'h00, "t6_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
